multicycle_main_controller: RTL and testbench

//  Main control FSM of the multicycle RV32I-subset core. Decodes op/func3 plus ALU flags each instruction and

---
 rtl/multicycle_main_controller_pkg.sv | 163 ++++++++++++++++
 rtl/multicycle_main_controller_if.sv | 30 +++
 rtl/multicycle_main_controller_branch_cond.sv | 20 ++
 rtl/multicycle_main_controller.sv | 61 ++++++
 tb/tb_multicycle_main_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_main_controller_pkg.sv
// Shared control constants, state encoding and state-only decode for the multicycle core.
// Build option ILLEGAL_TRAP_EN adds the HALT state.
package ctrl_pkg;
    localparam int ST_BITS = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [ST_BITS-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_ADR  = 4'd11,
        S_LUI       = 4'd12
`ifdef ILLEGAL_TRAP_EN
        , S_HALT    = 4'd13
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    function automatic state_t next_state(input state_t s, input logic [6:0] op);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:    n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_R:          n = S_EXEC_R;
                    OP_I:          n = S_EXEC_I;
                    OP_LW, OP_SW:  n = S_MEM_ADR;
                    OP_BR:         n = S_BRANCH;
                    OP_JAL:        n = S_JAL;
                    OP_JALR:       n = S_JALR_ADR;
                    OP_LUI:        n = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:       n = S_HALT;
`else
                    default:       n = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADR:  n = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: n = S_MEM_WB;
            S_EXEC_R,
            S_EXEC_I,
            S_JAL:      n = S_ALU_WB;
            S_JALR_ADR: n = S_JAL;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:     n = S_HALT;
`endif
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    // op-dependent imm_src and the branch pc_write are overlaid by the top.
    function automatic ctrl_t moore_outs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1; c.pc_write = 1'b1;
                c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR;
                c.alu_op = ALUOP_ADD; c.result_src = RES_ALURES;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM;
                c.imm_src = IMM_B; c.alu_op = ALUOP_ADD;
            end
            S_MEM_ADR, S_JALR_ADR: begin
                c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM;
                c.imm_src = IMM_I; c.alu_op = ALUOP_ADD;
            end
            S_MEM_READ:  c.adr_src = 1'b1;
            S_MEM_WB: begin
                c.result_src = RES_MEM; c.reg_write = 1'b1; c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.adr_src = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_R;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM;
                c.imm_src = IMM_I; c.alu_op = ALUOP_I;
            end
            S_ALU_WB: begin
                c.result_src = RES_ALUOUT; c.reg_write = 1'b1; c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2;
                c.alu_op = ALUOP_SUB; c.result_src = RES_ALUOUT; c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
                c.alu_op = ALUOP_ADD; c.result_src = RES_ALUOUT; c.pc_write = 1'b1;
            end
            S_LUI: begin
                c.imm_src = IMM_U; c.result_src = RES_IMM;
                c.reg_write = 1'b1; c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/multicycle_main_controller_if.sv
// Control bundle between the main controller (master) and the datapath (slave).
interface multicycle_main_controller_if;
    logic [6:0] op;
    logic [2:0] func3;
    logic       zero;
    logic       neg;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
    logic       instr_done;

    modport master (
        input  op, func3, zero, neg,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_op, instr_done
    );

    modport slave (
        output op, func3, zero, neg,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_op, instr_done
    );
endinterface

// File: rtl/multicycle_main_controller_branch_cond.sv
// Branch decision from func3 and the ALU flags of RD1-RD2; unsupported func3 never branches.
module branch_cond
    import ctrl_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       neg,
    output logic       take
);
    always_comb begin
        take = 1'b0;
        case (func3)
            F3_BEQ:  take = zero;
            F3_BNE:  take = ~zero;
            F3_BLT:  take = neg;
            F3_BGE:  take = ~neg;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multicycle RV32I-subset core.
// Build option ILLEGAL_TRAP_EN: unknown opcodes park the FSM in HALT until reset.
module multicycle_main_controller
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    multicycle_main_controller_if.master bus
);
    logic [STATE_W-1:0] state_q;
    state_t             cur, nxt;
    ctrl_t              outs_q, ctl;
    logic               take;

    assign cur = state_t'(state_q[ST_BITS-1:0]);
    assign nxt = next_state(cur, bus.op);

    // Outputs are registered from the next state so they are valid at the start of each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_W'(S_FETCH);
            outs_q  <= moore_outs(S_FETCH);
        end else begin
            state_q <= STATE_W'(nxt);
            outs_q  <= moore_outs(nxt);
        end
    end

    branch_cond u_branch_cond (
        .func3 (bus.func3),
        .zero  (bus.zero),
        .neg   (bus.neg),
        .take  (take)
    );

    // IR (op) is only valid after FETCH, so op-dependent fields cannot be pre-registered.
    always_comb begin
        ctl = outs_q;
        case (cur)
            S_DECODE:  ctl.imm_src  = (bus.op == OP_JAL) ? IMM_J : IMM_B;
            S_MEM_ADR: ctl.imm_src  = (bus.op == OP_SW)  ? IMM_S : IMM_I;
            S_BRANCH:  ctl.pc_write = take;
            default:   ;
        endcase
        if (rst) ctl = '0;
    end

    assign bus.pc_write   = ctl.pc_write;
    assign bus.adr_src    = ctl.adr_src;
    assign bus.mem_write  = ctl.mem_write;
    assign bus.ir_write   = ctl.ir_write;
    assign bus.reg_write  = ctl.reg_write;
    assign bus.result_src = ctl.result_src;
    assign bus.alu_src_a  = ctl.alu_src_a;
    assign bus.alu_src_b  = ctl.alu_src_b;
    assign bus.imm_src    = ctl.imm_src;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.instr_done = ctl.instr_done;
endmodule

// File: tb/tb_multicycle_main_controller.sv
// Bench for multicycle_main_controller: per-instruction cycle model, vector table, random instructions.
module tb_multicycle_main_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_main_controller_if bus();
    multicycle_main_controller #(.STATE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic pcw, adr, memw, irw, regw;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [1:0] aop;
        logic done;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z, n;
        int         len;
        logic [4:0] fin; // {pc_write, reg_write, mem_write, result_src} in the done cycle
    } tv_t;

    int tests = 0;
    int fails = 0;
    out_t got;

    assign got = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                  bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_op,
                  bus.instr_done};

    // Cycle count from fetch to completion; unknown opcodes spend only FETCH+DECODE.
    function automatic int ilen(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0100011, 7'b1101111: return 4;
            7'b0000011, 7'b1100111:                         return 5;
            7'b1100011, 7'b0110111:                         return 3;
            default:                                        return 2;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic n);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n;
            3'b101:  return !n;
            default: return 1'b0;
        endcase
    endfunction

    // Expected outputs at cycle k (0 = fetch) of one instruction.
    function automatic out_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic z, input logic n, input int k);
        out_t v;
        out_t wb;
        out_t link;
        out_t addr;
        int j;
        v = '0;
        wb = '0;   wb.regw = 1; wb.done = 1;
        link = '0; link.sa = 2'd1; link.sb = 2'd2; link.pcw = 1;
        addr = '0; addr.sa = 2'd2; addr.sb = 2'd1;
        j = k - 2;
        if (k == 0) begin
            v.irw = 1; v.pcw = 1; v.sb = 2'd2; v.rs = 2'd2;
        end else if (k == 1) begin
            v.sa = 2'd1; v.sb = 2'd1; v.imm = (op == 7'b1101111) ? 3'd3 : 3'd2;
        end else begin
            case (op)
                7'b0110011: if (j == 0) begin v.sa = 2'd2; v.aop = 2'd2; end else v = wb;
                7'b0010011: if (j == 0) begin v = addr; v.aop = 2'd3; end else v = wb;
                7'b0000011: begin
                    if (j == 0) v = addr;
                    else if (j == 1) v.adr = 1;
                    else begin v = wb; v.rs = 2'd1; end
                end
                7'b0100011: begin
                    if (j == 0) begin v = addr; v.imm = 3'd1; end
                    else begin v.adr = 1; v.memw = 1; v.done = 1; end
                end
                7'b1100011: begin
                    v.sa = 2'd2; v.aop = 2'd1; v.done = 1; v.pcw = taken(f3, z, n);
                end
                7'b1101111: v = (j == 0) ? link : wb;
                7'b1100111: v = (j == 0) ? addr : (j == 1) ? link : wb;
                7'b0110111: begin v.imm = 3'd4; v.rs = 2'd3; v.regw = 1; v.done = 1; end
                default:    v = '0; // HALT
            endcase
        end
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] g, input logic [31:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic n);
        bus.op = op; bus.func3 = f3; bus.zero = z; bus.neg = n;
    endtask

    // Entered and left at negedge+1 of a FETCH cycle; the loop is bounded by the model length.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input logic n, output int done_at, output out_t last);
        set_in(op, f3, z, n);
        #1;
        done_at = 0;
        last = '0;
        for (int k = 0; k < ilen(op); k++) begin
            check($sformatf("op%b f3%b z%0b n%0b k%0d", op, f3, z, n, k),
                  32'(got), 32'(model(op, f3, z, n, k)));
            if (got.done && done_at == 0) done_at = k + 1;
            last = got;
            step();
        end
    endtask

    tv_t  tv[15];
    int   d;
    out_t last;
    logic [6:0] legal_ops[8];

    initial begin
        tv[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 5'b01000}; // add
        tv[1]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 5'b01000}; // addi
        tv[2]  = '{7'b0000011, 3'b010, 1'b0, 1'b1, 5, 5'b01001}; // lw
        tv[3]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 5'b00100}; // sw
        tv[4]  = '{7'b1100011, 3'b000, 1'b1, 1'b0, 3, 5'b10000}; // beq taken
        tv[5]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 5'b00000}; // beq not taken
        tv[6]  = '{7'b1100011, 3'b001, 1'b0, 1'b0, 3, 5'b10000}; // bne taken
        tv[7]  = '{7'b1100011, 3'b100, 1'b0, 1'b1, 3, 5'b10000}; // blt taken
        tv[8]  = '{7'b1100011, 3'b101, 1'b0, 1'b1, 3, 5'b00000}; // bge not taken
        tv[9]  = '{7'b1100011, 3'b101, 1'b1, 1'b0, 3, 5'b10000}; // bge taken
        tv[10] = '{7'b1100011, 3'b010, 1'b1, 1'b1, 3, 5'b00000}; // unsupported func3
        tv[11] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 5'b01000}; // jal
        tv[12] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 5, 5'b01000}; // jalr
        tv[13] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 3, 5'b01011}; // lui
        tv[14] = '{7'b1100011, 3'b001, 1'b1, 1'b1, 3, 5'b00000}; // bne not taken
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

        // Reset held two cycles: everything forced low.
        rst = 1'b1;
        set_in(7'b0110011, 3'b000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        step();
        check("reset_outputs", 32'(got), 32'd0);
        rst = 1'b0;

        foreach (tv[i]) begin
            run_instr(tv[i].op, tv[i].f3, tv[i].z, tv[i].n, d, last);
            check($sformatf("tv%0d done_cycle", i), 32'(d), 32'(tv[i].len));
            check($sformatf("tv%0d final_writes", i),
                  32'({last.pcw, last.regw, last.memw, last.rs}), 32'(tv[i].fin));
        end

        // Branch decision follows the flags combinationally inside BRANCH.
        set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
        #1;
        step();
        step();
        check("br_live z0", 32'(got.pcw), 32'd0);
        bus.zero = 1'b1;
        #1;
        check("br_live z1", 32'(got.pcw), 32'd1);
        step();

        // Reset mid-lw (in MEM_READ) aborts with no writes, then restarts at FETCH.
        set_in(7'b0000011, 3'b000, 1'b0, 1'b0);
        #1;
        repeat (3) step();
        check("lw_memread_adr", 32'(got.adr), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_abort_comb", 32'(got), 32'd0);
        step();
        check("rst_abort_hold", 32'(got), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_abort_fetch", 32'(got), 32'(model(7'b0000011, 3'b000, 1'b0, 1'b0, 0)));
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, d, last);
        check("post_abort_add_done", 32'(d), 32'd4);

        // Unknown opcode.
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, d, last);
        check("illegal_no_done", 32'(d), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++) check($sformatf("halt k%0d", k), 32'(got), 32'd0) , step();
        rst = 1'b1;
        step();
        check("halt_rst", 32'(got), 32'd0);
        rst = 1'b0;
        #1;
`endif
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, d, last);
        check("after_illegal_lui_done", 32'(d), 32'd3);

        // Random instruction stream against the cycle model.
        for (int i = 0; i < 300; i++) begin
            logic [6:0] op;
            op = legal_ops[$urandom_range(0, 7)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
`endif
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), d, last);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
